// File: rtl/audio_out_buffer_if.sv
// Stream interface of the audio output buffer: filter-stage input and codec-side output.
//
// Handshake: the input side is a one-cycle strobe with no back-pressure. A pair on
// left_in/right_in is offered whenever in_valid is high, and the buffer either stores
// it or drops it in that same cycle. On the output side, write_ready means the codec
// can take a pair this cycle. write high means writedata_* is consumed at the next
// rising clock edge. write never rises unless write_ready is high.
interface audio_out_buffer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] left_in;
    logic [DATA_WIDTH-1:0] right_in;
    logic                  write_ready;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata_left;
    logic [DATA_WIDTH-1:0] writedata_right;

    // Producer of samples and owner of the codec ready line.
    modport master (
        output in_valid, left_in, right_in, write_ready,
        input  write, writedata_left, writedata_right
    );

    // The buffer itself.
    modport slave (
        input  in_valid, left_in, right_in, write_ready,
        output write, writedata_left, writedata_right
    );
endinterface

// File: rtl/audio_out_buffer.sv
// Audio output buffer: a circular stereo-pair FIFO between the filter and the codec.
// It primes to half full before streaming. It drops pairs on overflow and returns
// to priming on underrun, with a sticky flag for each event.
module audio_out_buffer #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    audio_out_buffer_if.slave     bus,
    input  logic                  clear_err,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underrun,
    output logic                  state_dbg
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] THRESH_C = {2'b01, {(ADDR_WIDTH-1){1'b0}}};

    typedef enum logic {
        PRIME  = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                    state;
    logic [2*DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]     wr_ptr;
    logic [ADDR_WIDTH-1:0]     rd_ptr;
    logic [2*DATA_WIDTH-1:0]   head;
    logic                      pop;
    logic                      push;
    logic                      drop;
    logic                      starve;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // The codec consumes only while streaming and only when there is data to give.
    assign pop    = (state == STREAM) & bus.write_ready & ~empty;
    // A full buffer still accepts a pair when the head leaves in the same cycle.
    assign push   = bus.in_valid & (~full | pop);
    assign drop   = bus.in_valid & full & ~pop;
    assign starve = (state == STREAM) & bus.write_ready & empty;

    assign bus.write = pop;
    assign state_dbg = (state == STREAM);

    // Gating on empty keeps stale storage hidden after reset and after a drain.
    assign head = empty ? '0 : mem[rd_ptr];
    assign bus.writedata_left  = head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign bus.writedata_right = head[DATA_WIDTH-1:0];

    // Sample storage. It is not reset, because nothing reads it while count is zero.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {bus.left_in, bus.right_in};
        end
    end

    // Pointers and occupancy. The pointers wrap naturally at DEPTH-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push & ~pop) begin
                count <= count + 1'b1;
            end else if (pop & ~push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Prime/stream control plus the sticky flags. A new event wins over clear_err.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= PRIME;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            case (state)
                PRIME: begin
                    if (count >= THRESH_C) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (starve) begin
                        state <= PRIME;
                    end
                end
                default: state <= PRIME;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end

            if (starve) begin
                underrun <= 1'b1;
            end else if (clear_err) begin
                underrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_audio_out_buffer.sv
// Directed and randomized bench for audio_out_buffer (DEPTH=8, THRESH=4).
module tb_audio_out_buffer;
    localparam int DW     = 24;
    localparam int AW     = 3;
    localparam int DEPTH  = 8;
    localparam int THRESH = 4;

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          reset;
    logic          clear_err;
    logic [AW:0]   count;
    logic          full, empty, overflow, underrun, state_dbg;

    always #5 clock = ~clock;

    audio_out_buffer_if #(.DATA_WIDTH(DW)) bus ();

    audio_out_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .clear_err (clear_err),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underrun  (underrun),
        .state_dbg (state_dbg)
    );

    // ---------------- reference model / scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [2*DW-1:0] exp_q[$];   // pairs held by the buffer, head first
    bit          m_stream;       // model: codec is being fed
    bit          m_ovf;
    bit          m_und;
    bit          m_write;        // model: pair consumed this cycle
    int          pushed;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_stream = 1'b0;
        m_ovf    = 1'b0;
        m_und    = 1'b0;
        m_write  = 1'b0;
    endtask

    // Compare every output against what the model says the buffer shows right now.
    task automatic check_outputs();
        logic [2*DW-1:0] exp_head;
        m_write  = m_stream && bus.write_ready && (exp_q.size() > 0);
        exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("write",     64'(bus.write), 64'(m_write));
        check("writedata", 64'({bus.writedata_left, bus.writedata_right}), 64'(exp_head));
        check("count",     64'(count), 64'(exp_q.size()));
        check("full",      64'(full), 64'(exp_q.size() == DEPTH));
        check("empty",     64'(empty), 64'(exp_q.size() == 0));
        check("overflow",  64'(overflow), 64'(m_ovf));
        check("underrun",  64'(underrun), 64'(m_und));
        check("stream",    64'(state_dbg), 64'(m_stream));
    endtask

    // Advance the model across one rising edge, using the inputs currently applied.
    task automatic model_edge();
        int n;
        bit pu, ovf_ev, und_ev;
        n      = exp_q.size();
        pu     = bus.in_valid && (n < DEPTH || m_write);
        ovf_ev = bus.in_valid && (n == DEPTH) && !m_write;
        und_ev = m_stream && bus.write_ready && (n == 0);
        if (m_write) void'(exp_q.pop_front());
        if (pu) begin
            exp_q.push_back({bus.left_in, bus.right_in});
            pushed++;
        end
        if (!m_stream) begin
            if (n >= THRESH) m_stream = 1'b1;
        end else if (und_ev) begin
            m_stream = 1'b0;
        end
        m_ovf = ovf_ev ? 1'b1 : (clear_err ? 1'b0 : m_ovf);
        m_und = und_ev ? 1'b1 : (clear_err ? 1'b0 : m_und);
    endtask

    // ---------------- driver ----------------
    function automatic logic [2*DW-1:0] pair_of(input int v);
        logic [DW-1:0] l, r;
        l = DW'(v);
        r = DW'(-v);
        return {l, r};
    endfunction

    // One clock cycle: apply inputs, check outputs at mid-cycle, take the edge.
    task automatic cycle(input bit iv, input int v, input bit wr, input bit ce);
        logic [2*DW-1:0] p;
        p = pair_of(v);
        bus.in_valid    = iv;
        bus.left_in     = p[2*DW-1:DW];
        bus.right_in    = p[DW-1:0];
        bus.write_ready = wr;
        clear_err       = ce;
        #4;
        check_outputs();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.write_ready = 1'b0;
        clear_err = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.left_in     = '0;
        bus.right_in    = '0;
        bus.write_ready = 1'b0;
        clear_err       = 1'b0;
        pushed          = 0;
        model_reset();
        #12;
        check_outputs();               // reset state
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Priming: three pairs are not enough, the fourth starts the stream.
        for (int i = 1; i <= 3; i++) cycle(1, i, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 4, 1, 0);
        cycle(0, 0, 0, 0);              // count 4, still priming
        cycle(0, 0, 1, 0);              // streaming: (1,-1) consumed

        // Overflow: nine pairs into an eight-deep buffer with the codec stalled.
        do_reset();
        for (int i = 10; i < 19; i++) cycle(1, i, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 50, 0, 1);             // clear_err together with a new drop
        cycle(0, 0, 0, 1);              // plain clear
        cycle(0, 0, 0, 0);

        // Full and streaming: push and pop each cycle keeps count at DEPTH.
        for (int i = 20; i < 30; i++) cycle(1, i, 1, 0);

        // Drain with no input until the buffer starves.
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);              // clear underrun
        for (int i = 31; i < 34; i++) cycle(1, i, 1, 0);
        cycle(0, 0, 1, 0);              // three pairs: still priming
        cycle(1, 34, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);

        // Asynchronous reset in the middle of a cycle while write is high.
        do_reset();
        for (int i = 60; i < 65; i++) cycle(1, i, 0, 0);
        bus.in_valid    = 1'b0;
        bus.write_ready = 1'b1;
        #2;
        check_outputs();               // count 5, write high
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();               // everything cleared before the edge
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Random streaming of 40 pairs with the codec ready pattern 1,0,1,1,0.
        pushed = 0;
        for (int c = 0; c < 2000 && pushed < 40; c++) begin
            bit wr, iv;
            wr = (c % 5 == 0) || (c % 5 == 2) || (c % 5 == 3);
            iv = ($urandom_range(0, 4) < 2);
            cycle(iv, 100 + pushed, wr, 0);
        end
        check("stim_bound", 64'(pushed), 64'(40));
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) cycle(0, 0, 1, 0);
        check("drain_bound", 64'(exp_q.size()), 64'(0));
        cycle(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/audio_out_buffer.md
AUDIO_OUT_BUFFER -- requirements
Module: audio_out_buffer

Interface
REQ-001 Parameter: DATA_WIDTH, 24, width of one audio channel sample.
REQ-002 Parameter: ADDR_WIDTH, 4, log2 of buffer depth; DEPTH = 2^ADDR_WIDTH stereo pairs, THRESH = DEPTH/2.
REQ-003 Port: clock  input  1  single clock for all logic.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  one-cycle strobe; filtered stereo pair is presented this cycle.
REQ-006 Port: left_in, right_in  input  DATA_WIDTH each  filtered samples from the filter stage.
REQ-007 Port: write_ready  input  1  codec can accept a stereo pair this cycle.
REQ-008 Port: clear_err  input  1  synchronous clear of sticky flags.
REQ-009 Port: write  output  1  pair on writedata_* is consumed by the codec this cycle.
REQ-010 Port: writedata_left, writedata_right  output  DATA_WIDTH each  buffer head pair.
REQ-011 Port: count  output  ADDR_WIDTH+1  stored pairs, 0..DEPTH.
REQ-012 Port: full, empty  output  1 each  count==DEPTH, count==0.
REQ-013 Port: overflow, underrun  output  1 each  sticky error flags.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH entries, each {left,right}, read/write pointers ADDR_WIDTH bits wrapping DEPTH-1 -> 0.
REQ-015 pop SHALL equal write; write = (state==STREAM) & write_ready & ~empty, combinational from registered state/count.
REQ-016 writedata_* SHALL show the head entry combinationally whenever ~empty, and all-zero when empty.
REQ-017 Push SHALL occur when in_valid & (~full | pop); a pair pushed at edge k is visible at head (if buffer was empty) in cycle after k.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order, including when full or holding one entry.
REQ-019 in_valid & full & ~pop SHALL drop the pair, leave count/pointers unchanged, and set overflow at that edge.
REQ-020 FSM states: PRIME, STREAM.
REQ-021 PRIME: write held 0; transition to STREAM at the first edge where registered count >= THRESH.
REQ-022 STREAM: when write_ready & empty, set underrun and return to PRIME at that edge; otherwise remain in STREAM.
REQ-023 Overflow/underrun SHALL stay set until reset or clear_err; clear_err coincident with a new error event SHALL leave the flag set.
REQ-024 Samples SHALL pass bit-exact; no arithmetic applied.

Reset
REQ-025 On reset assertion, immediately and without clock: state=PRIME, pointers=0, count=0, empty=1, full=0, write=0, writedata_*=0, overflow=0, underrun=0.
REQ-026 Storage contents need not be reset; no output SHALL expose stale storage after reset.
REQ-027 Reset mid-stream SHALL discard all buffered pairs; normal operation resumes on first edge after deassertion.

Verification (ADDR_WIDTH=3, DEPTH=8, THRESH=4)
REQ-028 Reset; write_ready=1; push pairs (1,-1),(2,-2),(3,-3) -> write=0, count=3; push (4,-4) -> count=4, STREAM next edge, then write=1 with writedata=(1,-1).
REQ-029 write_ready=0; push 9 pairs -> count=8, full=1, overflow=1, 9th pair absent from later drain output.
REQ-030 Full, STREAM, write_ready=1, in_valid=1 every cycle for 10 cycles -> count stays 8, overflow stays 0, output sequence matches input order.
REQ-031 STREAM with 2 pairs, in_valid=0, write_ready=1 -> 2 writes, then underrun=1, write=0, state PRIME; 4 further pushes needed before write reasserts.
REQ-032 Reset asserted mid-cycle while count=5 and write=1 -> write=0, count=0, writedata_*=0 before next clock edge.
REQ-033 Stream 40 pairs with write_ready toggling 1,0,1,1,0 and random in_valid at rate <= drain -> pointer wrap occurs, output order equals input order, no flags set.
